register_idex: RTL and testbench
================================

Name:
register_idex

Overview:
ID/EX pipeline register of the RV32I five-stage core. Captures decoded operands, PC values, the raw instruction and control signals from the decode stage on each enabled clock edge, and presents them to the execute stage. Also produces two registered hazard-detection flags, IDEXRegRead_out and IDEXMemRead, which the hazard unit uses for load-use stall detection.

Parameters:
XLEN, 32, datapath width for PC, instruction and operands
ALU_SEL_W, 4, width of the ALU operation select
WB_SEL_W, 2, width of the writeback source select
MEM_TYPE_W, 3, width of the memory access type (funct3 encoding)
NOP_INST, 32'h00000013, instruction value held after reset (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active low
en  in  1  load enable; 1 = capture inputs, 0 = hold (stall)
pc4_in / pc4_out  in/out  XLEN  PC+4 of the instruction
pc_in / pc_out  in/out  XLEN  PC of the instruction
inst_in / inst_out  in/out  XLEN  raw instruction word
operand1_in / operand1_out  in/out  XLEN  ALU operand 1
operand2_in / operand2_out  in/out  XLEN  ALU operand 2
instruction_rd_in / instruction_rd_out  in/out  5  destination register index
rs2_in / rs2_out  in/out  5  source register 2 index (store data, forwarding)
prediction_in / prediction_out  in/out  1  branch prediction taken
register_write_enable_in / register_write_enable_out  in/out  1  writeback enable
mem_request_write_in / mem_request_write_out  in/out  1  1 = store, 0 = load or no access
mem_request_type_in / mem_request_type_out  in/out  MEM_TYPE_W  access size and sign (funct3)
alu_sel_in / alu_sel_out  in/out  ALU_SEL_W  ALU operation
wb_sel_in / wb_sel_out  in/out  WB_SEL_W  writeback source
IDEXRegRead_out  out  1  latched instruction reads a source register
IDEXMemRead  out  1  latched instruction is a load

Behaviour:
- All outputs are flops; there is no combinational path from any input to any output.
- Reset: when rst = 0, all flops clear asynchronously, independent of clk and en.
  - inst_out = NOP_INST.
  - Every other output = 0, including both flags.
  - Outputs stay at reset values while rst is held low.
- Operation: on each rising clk edge with rst = 1 and en = 1, every *_out takes the value of its *_in. Latency is 1 cycle.
- Stall: on a rising clk edge with en = 0, all outputs hold their current values, including both flags.
- Flags are computed from inst_in opcode bits [6:0] and registered on the same edge as the other signals:
  - IDEXMemRead = 1 if and only if opcode = 7'b0000011 (LOAD).
  - IDEXRegRead_out = 1 for opcodes OP (0110011), OP-IMM (0010011), LOAD, STORE (0100011), BRANCH (1100011) and JALR (1100111).
  - IDEXRegRead_out = 0 for LUI, AUIPC, JAL and any unrecognised opcode.
- Reset released mid-cycle: outputs hold reset values until the first enabled rising edge.
- Reset asserted mid-operation: the clear is immediate and overrides a simultaneous clock edge.
- Width rule: pass-through fields are captured bit-exact, with no sign extension and no truncation.

Test Plan:
- Hold rst = 0, toggle clk -> inst_out = 0x00000013; all other outputs 0; IDEXMemRead = 0; IDEXRegRead_out = 0.
- rst = 1, en = 1, inst_in = 0x00200513, operand1_in = 0, operand2_in = 2, instruction_rd_in = 10, alu_sel_in = ADD, one edge -> outputs match the inputs after exactly 1 cycle; IDEXRegRead_out = 1; IDEXMemRead = 0.
- Next edge with inst_in = 0x00200593, instruction_rd_in = 11 -> inst_out = 0x00200593, instruction_rd_out = 11; the previous value held for the whole prior cycle.
- en = 0 while inputs change to inst_in = 0x0000A103 (lw) -> outputs unchanged for 3 cycles. Then en = 1 -> next edge gives inst_out = 0x0000A103 and IDEXMemRead = 1.
- inst_in = 0x000012B7 (lui), en = 1 -> IDEXRegRead_out = 0, IDEXMemRead = 0. Then load 0x00112023 (sw) with mem_request_write_in = 1, mem_request_type_in = 3'b010 -> mem_request_write_out = 1, mem_request_type_out = 010, IDEXRegRead_out = 1.
- With outputs loaded with non-zero values, drop rst between clock edges -> outputs reset immediately, before the next edge: inst_out = 0x00000013, everything else 0.

Source files
------------

// File: rtl/register_idex.sv
// ID/EX pipeline register: latches decode-stage results for execute
// and registers the load-use hazard flags derived from the opcode.
module register_idex #(
  parameter int XLEN       = 32,
  parameter int ALU_SEL_W  = 4,
  parameter int WB_SEL_W   = 2,
  parameter int MEM_TYPE_W = 3,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [XLEN-1:0]       pc4_in,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [XLEN-1:0]       inst_in,
  input  logic [XLEN-1:0]       operand1_in,
  input  logic [XLEN-1:0]       operand2_in,
  input  logic [4:0]            instruction_rd_in,
  input  logic [4:0]            rs2_in,
  input  logic                  prediction_in,
  input  logic                  register_write_enable_in,
  input  logic                  mem_request_write_in,
  input  logic [MEM_TYPE_W-1:0] mem_request_type_in,
  input  logic [ALU_SEL_W-1:0]  alu_sel_in,
  input  logic [WB_SEL_W-1:0]   wb_sel_in,
  output logic [XLEN-1:0]       pc4_out,
  output logic [XLEN-1:0]       pc_out,
  output logic [XLEN-1:0]       inst_out,
  output logic [XLEN-1:0]       operand1_out,
  output logic [XLEN-1:0]       operand2_out,
  output logic [4:0]            instruction_rd_out,
  output logic [4:0]            rs2_out,
  output logic                  prediction_out,
  output logic                  register_write_enable_out,
  output logic                  mem_request_write_out,
  output logic [MEM_TYPE_W-1:0] mem_request_type_out,
  output logic [ALU_SEL_W-1:0]  alu_sel_out,
  output logic [WB_SEL_W-1:0]   wb_sel_out,
  output logic                  IDEXRegRead_out,
  output logic                  IDEXMemRead
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [XLEN-1:0]       pc4_q, pc4_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       inst_q, inst_d;
  logic [XLEN-1:0]       op1_q, op1_d;
  logic [XLEN-1:0]       op2_q, op2_d;
  logic [4:0]            rd_q, rd_d;
  logic [4:0]            rs2_q, rs2_d;
  logic                  pred_q, pred_d;
  logic                  rwe_q, rwe_d;
  logic                  mwr_q, mwr_d;
  logic [MEM_TYPE_W-1:0] mtype_q, mtype_d;
  logic [ALU_SEL_W-1:0]  alu_q, alu_d;
  logic [WB_SEL_W-1:0]   wb_q, wb_d;
  logic                  rdreg_q, rdreg_d;
  logic                  mrd_q, mrd_d;

  logic [6:0] opcode;
  logic       is_load;
  logic       reads_reg;

  assign opcode = inst_in[6:0];

  // Flags describe the incoming instruction, so they load with it
  always_comb begin
    is_load   = 1'b0;
    reads_reg = 1'b0;
    unique case (opcode)
      OP_LOAD: begin
        is_load   = 1'b1;
        reads_reg = 1'b1;
      end
      OP_IMM, OP_STORE, OP_REG,
      OP_BRANCH, OP_JALR: reads_reg = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc4_d   = pc4_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    rs2_d   = rs2_q;
    pred_d  = pred_q;
    rwe_d   = rwe_q;
    mwr_d   = mwr_q;
    mtype_d = mtype_q;
    alu_d   = alu_q;
    wb_d    = wb_q;
    rdreg_d = rdreg_q;
    mrd_d   = mrd_q;
    if (en) begin
      pc4_d   = pc4_in;
      pc_d    = pc_in;
      inst_d  = inst_in;
      op1_d   = operand1_in;
      op2_d   = operand2_in;
      rd_d    = instruction_rd_in;
      rs2_d   = rs2_in;
      pred_d  = prediction_in;
      rwe_d   = register_write_enable_in;
      mwr_d   = mem_request_write_in;
      mtype_d = mem_request_type_in;
      alu_d   = alu_sel_in;
      wb_d    = wb_sel_in;
      rdreg_d = reads_reg;
      mrd_d   = is_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc4_q   <= '0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      rs2_q   <= '0;
      pred_q  <= 1'b0;
      rwe_q   <= 1'b0;
      mwr_q   <= 1'b0;
      mtype_q <= '0;
      alu_q   <= '0;
      wb_q    <= '0;
      rdreg_q <= 1'b0;
      mrd_q   <= 1'b0;
    end else begin
      pc4_q   <= pc4_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      rs2_q   <= rs2_d;
      pred_q  <= pred_d;
      rwe_q   <= rwe_d;
      mwr_q   <= mwr_d;
      mtype_q <= mtype_d;
      alu_q   <= alu_d;
      wb_q    <= wb_d;
      rdreg_q <= rdreg_d;
      mrd_q   <= mrd_d;
    end
  end

  assign pc4_out                   = pc4_q;
  assign pc_out                    = pc_q;
  assign inst_out                  = inst_q;
  assign operand1_out              = op1_q;
  assign operand2_out              = op2_q;
  assign instruction_rd_out        = rd_q;
  assign rs2_out                   = rs2_q;
  assign prediction_out            = pred_q;
  assign register_write_enable_out = rwe_q;
  assign mem_request_write_out     = mwr_q;
  assign mem_request_type_out      = mtype_q;
  assign alu_sel_out               = alu_q;
  assign wb_sel_out                = wb_q;
  assign IDEXRegRead_out           = rdreg_q;
  assign IDEXMemRead               = mrd_q;

endmodule

// File: tb/tb_register_idex.sv
// Bench for register_idex: directed steps then random traffic
// against a field-level reference model.
module tb_register_idex;

  logic        clk, rst, en;
  logic [31:0] pc4_in, pc_in, inst_in, op1_in, op2_in;
  logic [4:0]  rd_in, rs2_in;
  logic        pred_in, rwe_in, mwr_in;
  logic [2:0]  mtype_in;
  logic [3:0]  alu_in;
  logic [1:0]  wb_in;

  logic [31:0] pc4_o, pc_o, inst_o, op1_o, op2_o;
  logic [4:0]  rd_o, rs2_o;
  logic        pred_o, rwe_o, mwr_o;
  logic [2:0]  mtype_o;
  logic [3:0]  alu_o;
  logic [1:0]  wb_o;
  logic        rr_o, mr_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_pc4, m_pc, m_inst, m_op1, m_op2;
  logic [4:0]  m_rd, m_rs2;
  logic        m_pred, m_rwe, m_mwr, m_rr, m_mr;
  logic [2:0]  m_mtype;
  logic [3:0]  m_alu;
  logic [1:0]  m_wb;

  register_idex dut (
    .clk(clk), .rst(rst), .en(en),
    .pc4_in(pc4_in), .pc_in(pc_in), .inst_in(inst_in),
    .operand1_in(op1_in), .operand2_in(op2_in),
    .instruction_rd_in(rd_in), .rs2_in(rs2_in),
    .prediction_in(pred_in),
    .register_write_enable_in(rwe_in),
    .mem_request_write_in(mwr_in),
    .mem_request_type_in(mtype_in),
    .alu_sel_in(alu_in), .wb_sel_in(wb_in),
    .pc4_out(pc4_o), .pc_out(pc_o), .inst_out(inst_o),
    .operand1_out(op1_o), .operand2_out(op2_o),
    .instruction_rd_out(rd_o), .rs2_out(rs2_o),
    .prediction_out(pred_o),
    .register_write_enable_out(rwe_o),
    .mem_request_write_out(mwr_o),
    .mem_request_type_out(mtype_o),
    .alu_sel_out(alu_o), .wb_sel_out(wb_o),
    .IDEXRegRead_out(rr_o), .IDEXMemRead(mr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_reader(logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  task automatic model_reset();
    m_pc4 = 0; m_pc = 0; m_inst = 32'h00000013;
    m_op1 = 0; m_op2 = 0; m_rd = 0; m_rs2 = 0;
    m_pred = 0; m_rwe = 0; m_mwr = 0; m_mtype = 0;
    m_alu = 0; m_wb = 0; m_rr = 0; m_mr = 0;
  endtask

  task automatic model_load();
    m_pc4 = pc4_in; m_pc = pc_in; m_inst = inst_in;
    m_op1 = op1_in; m_op2 = op2_in;
    m_rd = rd_in; m_rs2 = rs2_in; m_pred = pred_in;
    m_rwe = rwe_in; m_mwr = mwr_in; m_mtype = mtype_in;
    m_alu = alu_in; m_wb = wb_in;
    m_rr = is_reader(inst_in[6:0]);
    m_mr = (inst_in[6:0] == 7'h03);
  endtask

  task automatic check_all(string ctx);
    chk({ctx, ".pc4"},   pc4_o,   m_pc4);
    chk({ctx, ".pc"},    pc_o,    m_pc);
    chk({ctx, ".inst"},  inst_o,  m_inst);
    chk({ctx, ".op1"},   op1_o,   m_op1);
    chk({ctx, ".op2"},   op2_o,   m_op2);
    chk({ctx, ".rd"},    32'(rd_o),    32'(m_rd));
    chk({ctx, ".rs2"},   32'(rs2_o),   32'(m_rs2));
    chk({ctx, ".pred"},  32'(pred_o),  32'(m_pred));
    chk({ctx, ".rwe"},   32'(rwe_o),   32'(m_rwe));
    chk({ctx, ".mwr"},   32'(mwr_o),   32'(m_mwr));
    chk({ctx, ".mtype"}, 32'(mtype_o), 32'(m_mtype));
    chk({ctx, ".alu"},   32'(alu_o),   32'(m_alu));
    chk({ctx, ".wb"},    32'(wb_o),    32'(m_wb));
    chk({ctx, ".rr"},    32'(rr_o),    32'(m_rr));
    chk({ctx, ".mr"},    32'(mr_o),    32'(m_mr));
  endtask

  // one clock: inputs already driven at negedge, check at next negedge
  task automatic tick(string ctx);
    @(posedge clk);
    if (rst && en) model_load();
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic rand_inputs();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h67, 7'h37, 7'h17, 7'h6f, 7'h00};
    w = $urandom;
    if ($urandom_range(0, 4) != 0)
      w[6:0] = ops[$urandom_range(0, 9)];
    inst_in = w;
    pc4_in = $urandom; pc_in = $urandom;
    op1_in = $urandom; op2_in = $urandom;
    rd_in = 5'($urandom); rs2_in = 5'($urandom);
    pred_in = 1'($urandom); rwe_in = 1'($urandom);
    mwr_in = 1'($urandom); mtype_in = 3'($urandom);
    alu_in = 4'($urandom); wb_in = 2'($urandom);
  endtask

  // drop reset between edges; clear must be visible before next edge
  task automatic mid_reset(string ctx);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all({ctx, ".async"});
    @(posedge clk);
    @(negedge clk);
    check_all({ctx, ".held"});
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1;
    rand_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");

    rst = 1'b1;
    inst_in = 32'h00200513; op1_in = 0; op2_in = 2;
    rd_in = 10; alu_in = 4'd0;
    tick("addi_a0");

    inst_in = 32'h00200593; rd_in = 11;
    tick("addi_a1");

    en = 1'b0;
    inst_in = 32'h0000A103; rd_in = 2;
    tick("stall1");
    pc_in = 32'hdead_beef;
    tick("stall2");
    op1_in = 32'h1234_5678;
    tick("stall3");
    en = 1'b1;
    tick("lw");

    inst_in = 32'h000012B7; rd_in = 5;
    tick("lui");

    inst_in = 32'h00112023; mwr_in = 1'b1;
    mtype_in = 3'b010;
    tick("sw");

    mid_reset("dir");

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      en = ($urandom_range(0, 3) != 0);
      tick("rnd");
      if ($urandom_range(0, 24) == 0) mid_reset("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
